// File: rtl/dec_stage.sv
// dec_stage: RV32I decode stage with a 2-entry output FIFO.
//
// Decodes a fetch bundle of WIDTH lanes into per-lane register addresses,
// sign-extended immediates, unit enables and ALU/extra opcodes. Decoded
// bundles are registered into a 2-entry FIFO (output register + skid entry).
// Nothing is forwarded combinationally from the input to the outputs.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   flush              drop all buffered bundles and the incoming bundle
//   in_valid/in_ready  fetch handshake; in_ready is registered (occupancy < 2)
//   in_pc              lane-0 PC of the incoming bundle
//   in_mask            per-lane instruction present
//   in_inst            WIDTH x 32 raw instructions (lane k at [32k +: 32])
//   out_valid/out_ready  decoded-bundle handshake
//   out_pc             lane-0 PC of the head bundle
//   out_lane_valid     per-lane decoded instruction valid
//   out_illegal        per-lane illegal-instruction flag
//   out_rs1/rs2/rd     WIDTH x 5 register addresses
//   out_imm            WIDTH x 32 immediates
//   out_en             WIDTH x 9 enables {rs1,rs2,imm,pc,alu,agu,bru,lsu,rd}
//   out_alu_opc        WIDTH x 4 ALU opcode
//   out_extra_opc      WIDTH x 4 BRU/LSU opcode
//   dec_count          saturating count of delivered legal instructions
module dec_stage #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned EN_M  = 0,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [WIDTH-1:0]     in_mask,
    input  logic [WIDTH*32-1:0]  in_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [WIDTH-1:0]     out_lane_valid,
    output logic [WIDTH-1:0]     out_illegal,
    output logic [WIDTH*5-1:0]   out_rs1,
    output logic [WIDTH*5-1:0]   out_rs2,
    output logic [WIDTH*5-1:0]   out_rd,
    output logic [WIDTH*32-1:0]  out_imm,
    output logic [WIDTH*9-1:0]   out_en,
    output logic [WIDTH*4-1:0]   out_alu_opc,
    output logic [WIDTH*4-1:0]   out_extra_opc,
    output logic [CNT_W-1:0]     dec_count
);

    // Enable packet bit positions
    localparam int unsigned EN_RS1 = 8;
    localparam int unsigned EN_RS2 = 7;
    localparam int unsigned EN_IMM = 6;
    localparam int unsigned EN_PC  = 5;
    localparam int unsigned EN_ALU = 4;
    localparam int unsigned EN_AGU = 3;
    localparam int unsigned EN_BRU = 2;
    localparam int unsigned EN_LSU = 1;
    localparam int unsigned EN_RD  = 0;

    typedef struct packed {
        logic        illegal;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [8:0]  en;
        logic [3:0]  alu_opc;
        logic [3:0]  extra_opc;
    } lane_t;

    // Control part of a bundle: reset
    typedef struct packed {
        logic [WIDTH-1:0] lane_valid;
        logic [WIDTH-1:0] illegal;
    } ctl_t;

    // Data part of a bundle: not reset
    typedef struct packed {
        logic [31:0]         pc;
        logic [WIDTH*5-1:0]  rs1;
        logic [WIDTH*5-1:0]  rs2;
        logic [WIDTH*5-1:0]  rd;
        logic [WIDTH*32-1:0] imm;
        logic [WIDTH*9-1:0]  en;
        logic [WIDTH*4-1:0]  alu_opc;
        logic [WIDTH*4-1:0]  extra_opc;
    } dat_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic lane_t decode(input logic [31:0] i);
        lane_t      d;
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = i[31:25];
        f3 = i[14:12];
        d = '0;
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.rd  = i[11:7];
        case (i[6:0])
            7'b0110111: begin // LUI
                d.imm = {i[31:12], 12'b0};
                d.en[EN_IMM] = 1'b1; d.en[EN_ALU] = 1'b1; d.en[EN_RD] = 1'b1;
            end
            7'b0010111: begin // AUIPC
                d.imm = {i[31:12], 12'b0};
                d.en[EN_IMM] = 1'b1; d.en[EN_PC] = 1'b1;
                d.en[EN_ALU] = 1'b1; d.en[EN_RD] = 1'b1;
            end
            7'b1101111: begin // JAL
                d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                d.en[EN_IMM] = 1'b1; d.en[EN_PC] = 1'b1;
                d.en[EN_BRU] = 1'b1; d.en[EN_RD] = 1'b1;
                d.extra_opc = 4'b1000;
            end
            7'b1100111: begin // JALR
                d.imm = {{20{i[31]}}, i[31:20]};
                d.en[EN_RS1] = 1'b1; d.en[EN_IMM] = 1'b1;
                d.en[EN_BRU] = 1'b1; d.en[EN_RD] = 1'b1;
                d.extra_opc = 4'b1001;
                d.illegal = (f3 != 3'b000);
            end
            7'b1100011: begin // BRANCH: ALU does the compare (SLT / SLTU)
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                d.en[EN_RS1] = 1'b1; d.en[EN_RS2] = 1'b1; d.en[EN_IMM] = 1'b1;
                d.en[EN_PC]  = 1'b1; d.en[EN_ALU] = 1'b1; d.en[EN_BRU] = 1'b1;
                d.alu_opc   = {3'b001, f3[1]};
                d.extra_opc = {1'b0, f3};
                d.illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            7'b0000011: begin // LOAD
                d.imm = {{20{i[31]}}, i[31:20]};
                d.en[EN_RS1] = 1'b1; d.en[EN_IMM] = 1'b1; d.en[EN_AGU] = 1'b1;
                d.en[EN_LSU] = 1'b1; d.en[EN_RD]  = 1'b1;
                d.extra_opc = {1'b0, f3};
                d.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            7'b0100011: begin // STORE
                d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                d.en[EN_RS1] = 1'b1; d.en[EN_RS2] = 1'b1; d.en[EN_IMM] = 1'b1;
                d.en[EN_AGU] = 1'b1; d.en[EN_LSU] = 1'b1;
                d.extra_opc = {1'b1, f3};
                d.illegal = (f3 >= 3'b011);
            end
            7'b0010011: begin // OP-IMM
                d.imm = {{20{i[31]}}, i[31:20]};
                d.en[EN_RS1] = 1'b1; d.en[EN_IMM] = 1'b1;
                d.en[EN_ALU] = 1'b1; d.en[EN_RD]  = 1'b1;
                d.alu_opc = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
                if (f3 == 3'b001)
                    d.illegal = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    d.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            7'b0110011: begin // OP
                d.en[EN_RS1] = 1'b1; d.en[EN_RS2] = 1'b1;
                d.en[EN_ALU] = 1'b1; d.en[EN_RD]  = 1'b1;
                if (f7 == 7'b0000000) begin
                    d.alu_opc = {1'b0, f3};
                end else if (f7 == 7'b0100000) begin
                    d.alu_opc = {1'b1, f3};
                    d.illegal = (f3 != 3'b000) && (f3 != 3'b101);
                end else if ((f7 == 7'b0000001) && (EN_M != 0)) begin
                    d.alu_opc = {1'b1, f3};
                end else begin
                    d.illegal = 1'b1;
                end
            end
            7'b0001111, 7'b1110011: begin // MISC-MEM / SYSTEM: legal, no units
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) d.en = '0;
        return d;
    endfunction

    // Incoming bundle decode
    ctl_t  in_ctl;
    dat_t  in_dat;
    lane_t lane;
    logic  killed;
    logic  present;

    always_comb begin
        in_ctl  = '0;
        in_dat  = '0;
        lane    = '0;
        killed  = 1'b0;
        present = 1'b0;
        in_dat.pc = in_pc;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            lane    = decode(in_inst[k*32 +: 32]);
            present = in_mask[k] && !killed;
            in_ctl.lane_valid[k] = present;
            in_ctl.illegal[k]    = present && lane.illegal;
            // Everything after the first illegal lane is squashed
            if (present && lane.illegal) killed = 1'b1;
            in_dat.rs1[k*5 +: 5]        = lane.rs1;
            in_dat.rs2[k*5 +: 5]        = lane.rs2;
            in_dat.rd[k*5 +: 5]         = lane.rd;
            in_dat.imm[k*32 +: 32]      = lane.imm;
            in_dat.en[k*9 +: 9]         = present ? lane.en : 9'b0;
            in_dat.alu_opc[k*4 +: 4]    = lane.alu_opc;
            in_dat.extra_opc[k*4 +: 4]  = lane.extra_opc;
        end
    end

    // FIFO state
    occ_e occ_q, occ_d;
    ctl_t head_ctl_q, head_ctl_d, skid_ctl_q, skid_ctl_d;
    dat_t head_dat_q, head_dat_d, skid_dat_q, skid_dat_d;
    logic in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic accept, pop;
    logic [2:0] pop_cnt;
    logic [CNT_W:0] cnt_sum;

    always_comb begin
        accept     = in_valid && in_ready_q && !flush;
        pop        = (occ_q != OCC_EMPTY) && out_ready;
        occ_d      = occ_q;
        head_ctl_d = head_ctl_q;
        head_dat_d = head_dat_q;
        skid_ctl_d = skid_ctl_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: if (accept) begin
                    head_ctl_d = in_ctl;
                    head_dat_d = in_dat;
                    occ_d      = OCC_ONE;
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        head_ctl_d = in_ctl;
                        head_dat_d = in_dat;
                    end else if (accept) begin
                        skid_ctl_d = in_ctl;
                        skid_dat_d = in_dat;
                        occ_d      = OCC_FULL;
                    end else if (pop) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: if (pop) begin
                    head_ctl_d = skid_ctl_q;
                    head_dat_d = skid_dat_q;
                    occ_d      = OCC_ONE;
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
        in_ready_d = (occ_d != OCC_FULL);
    end

    // Delivered-instruction counter, counts pops even in a flush cycle
    always_comb begin
        pop_cnt = '0;
        for (int unsigned k = 0; k < WIDTH; k++)
            pop_cnt = pop_cnt + 3'(head_ctl_q.lane_valid[k] & ~head_ctl_q.illegal[k]);
        cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(pop_cnt);
        cnt_d   = cnt_q;
        if (pop) cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= OCC_EMPTY;
            head_ctl_q <= '0;
            skid_ctl_q <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            head_ctl_q <= head_ctl_d;
            skid_ctl_q <= skid_ctl_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        head_dat_q <= head_dat_d;
        skid_dat_q <= skid_dat_d;
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = (occ_q != OCC_EMPTY);
    assign out_lane_valid = head_ctl_q.lane_valid & {WIDTH{out_valid}};
    assign out_illegal    = head_ctl_q.illegal & {WIDTH{out_valid}};
    assign out_pc         = head_dat_q.pc;
    assign out_rs1        = head_dat_q.rs1;
    assign out_rs2        = head_dat_q.rs2;
    assign out_rd         = head_dat_q.rd;
    assign out_imm        = head_dat_q.imm;
    assign out_en         = head_dat_q.en;
    assign out_alu_opc    = head_dat_q.alu_opc;
    assign out_extra_opc  = head_dat_q.extra_opc;
    assign dec_count      = cnt_q;

endmodule

// File: tb/tb_dec_stage.sv
module tb_dec_stage;

    localparam logic [31:0] ADDI5  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] BEQM8  = 32'hFE208CE3; // beq  x1,x2,-8
    localparam logic [31:0] ADD3   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] SUB3   = 32'h402081B3; // sub  x3,x1,x2
    localparam logic [31:0] MUL3   = 32'h022081B3; // mul  x3,x1,x2
    localparam logic [31:0] LW5    = 32'h00C12283; // lw   x5,12(x2)
    localparam logic [31:0] SW5    = 32'hFE512E23; // sw   x5,-4(x2)
    localparam logic [31:0] LUI7   = 32'h123453B7; // lui  x7,0x12345
    localparam logic [31:0] JAL16  = 32'h010000EF; // jal  x1,+16
    localparam logic [31:0] SRAI3  = 32'h4030D093; // srai x1,x1,3
    localparam logic [31:0] SRAIBD = 32'h4230D093; // srai with funct7=0100001

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_pc;
    logic [1:0]  in_mask;
    logic [63:0] in_inst;

    logic        in_ready, out_valid;
    logic [31:0] out_pc;
    logic [1:0]  out_lane_valid, out_illegal;
    logic [9:0]  out_rs1, out_rs2, out_rd;
    logic [63:0] out_imm;
    logic [17:0] out_en;
    logic [7:0]  out_alu_opc, out_extra_opc;
    logic [31:0] dec_count;

    logic        m_in_ready, m_out_valid;
    logic [31:0] m_out_pc;
    logic [1:0]  m_out_lane_valid, m_out_illegal;
    logic [9:0]  m_out_rs1, m_out_rs2, m_out_rd;
    logic [63:0] m_out_imm;
    logic [17:0] m_out_en;
    logic [7:0]  m_out_alu_opc, m_out_extra_opc;
    logic [3:0]  m_dec_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dec_stage #(.WIDTH(2), .EN_M(0), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_mask(in_mask), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_lane_valid(out_lane_valid), .out_illegal(out_illegal),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_en(out_en),
        .out_alu_opc(out_alu_opc), .out_extra_opc(out_extra_opc),
        .dec_count(dec_count)
    );

    dec_stage #(.WIDTH(2), .EN_M(1), .CNT_W(4)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_pc(in_pc),
        .in_mask(in_mask), .in_inst(in_inst),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_out_pc),
        .out_lane_valid(m_out_lane_valid), .out_illegal(m_out_illegal),
        .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd),
        .out_imm(m_out_imm), .out_en(m_out_en),
        .out_alu_opc(m_out_alu_opc), .out_extra_opc(m_out_extra_opc),
        .dec_count(m_dec_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [1:0] mask,
                         input logic [31:0] l1, input logic [31:0] l0);
        in_valid = 1'b1;
        in_pc    = pc;
        in_mask  = mask;
        in_inst  = {l1, l0};
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_mask = '0; in_inst = '0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_lane_valid", out_lane_valid, 2'b00);
        chk("rst_count", dec_count, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1'b1);

        // ADDI / BEQ bundle
        drive(32'h100, 2'b11, BEQM8, ADDI5);
        tick();
        in_valid = 1'b0;
        chk("b0_out_valid", out_valid, 1'b1);
        chk("b0_pc", out_pc, 32'h100);
        chk("b0_lane_valid", out_lane_valid, 2'b11);
        chk("b0_illegal", out_illegal, 2'b00);
        chk("b0_imm0", out_imm[31:0], 32'd5);
        chk("b0_imm1", out_imm[63:32], 32'hFFFFFFF8);
        chk("b0_alu1", out_alu_opc[7:4], 4'b0010);
        chk("b0_en0", out_en[8:0], 9'h151);
        chk("b0_en1", out_en[17:9], 9'h1F4);
        chk("b0_rd0", out_rd[4:0], 5'd1);
        chk("b0_rs1_1", out_rs1[9:5], 5'd1);
        chk("b0_rs2_1", out_rs2[9:5], 5'd2);
        tick();
        chk("b0_count", dec_count, 32'd2);
        chk("b0_drained", out_valid, 1'b0);

        // Illegal lane 0 squashes lane 1
        drive(32'h110, 2'b11, ADD3, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("kill0_illegal", out_illegal, 2'b01);
        chk("kill0_lane_valid", out_lane_valid, 2'b01);
        chk("kill0_en0", out_en[8:0], 9'h000);
        tick();
        chk("kill0_count", dec_count, 32'd2);

        // Legal SRAI in lane 0, bad-funct7 SRAI in lane 1
        drive(32'h120, 2'b11, SRAIBD, SRAI3);
        tick();
        in_valid = 1'b0;
        chk("srai_illegal", out_illegal, 2'b10);
        chk("srai_lane_valid", out_lane_valid, 2'b11);
        chk("srai_alu0", out_alu_opc[3:0], 4'b1101);
        tick();
        chk("srai_count", dec_count, 32'd3);

        // Masked-off lane 0 carries garbage
        drive(32'h130, 2'b10, ADDI5, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("mask_lane_valid", out_lane_valid, 2'b10);
        chk("mask_illegal", out_illegal, 2'b00);
        tick();
        chk("mask_count", dec_count, 32'd4);

        // MUL: illegal without M, legal with M
        drive(32'h140, 2'b01, 32'h0, MUL3);
        tick();
        in_valid = 1'b0;
        chk("mul_illegal_nom", out_illegal, 2'b01);
        chk("mul_illegal_m", m_out_illegal, 2'b00);
        chk("mul_alu_m", m_out_alu_opc[3:0], 4'b1000);
        chk("mul_en_m", m_out_en[8:0], 9'h191);
        tick();
        chk("mul_count", dec_count, 32'd4);

        drive(32'h150, 2'b01, 32'h0, SUB3);
        tick();
        in_valid = 1'b0;
        chk("sub_illegal", out_illegal, 2'b00);
        chk("sub_alu", out_alu_opc[3:0], 4'b1000);
        tick();
        chk("sub_count", dec_count, 32'd5);

        // Back-to-back bundles against a stalled consumer
        out_ready = 1'b0;
        drive(32'h200, 2'b11, SW5, LW5);
        tick();
        chk("stall_a_pc", out_pc, 32'h200);
        chk("stall_a_ready", in_ready, 1'b1);
        drive(32'h300, 2'b11, JAL16, LUI7);
        tick();
        chk("stall_full_ready", in_ready, 1'b0);
        drive(32'h400, 2'b11, ADD3, ADD3);
        tick();
        in_valid = 1'b0;
        chk("stall_hold_ready", in_ready, 1'b0);
        chk("stall_hold_pc", out_pc, 32'h200);
        chk("stall_imm0", out_imm[31:0], 32'd12);
        chk("stall_imm1", out_imm[63:32], 32'hFFFFFFFC);
        chk("stall_en0", out_en[8:0], 9'h14B);
        chk("stall_en1", out_en[17:9], 9'h1CA);
        chk("stall_xop0", out_extra_opc[3:0], 4'b0010);
        chk("stall_xop1", out_extra_opc[7:4], 4'b1010);
        out_ready = 1'b1;
        tick();
        chk("rel_b_valid", out_valid, 1'b1);
        chk("rel_b_pc", out_pc, 32'h300);
        chk("rel_b_ready", in_ready, 1'b1);
        chk("rel_b_imm0", out_imm[31:0], 32'h12345000);
        chk("rel_b_imm1", out_imm[63:32], 32'h10);
        chk("rel_b_rd0", out_rd[4:0], 5'd7);
        chk("rel_a_count", dec_count, 32'd7);
        tick();
        chk("rel_c_absent", out_valid, 1'b0);
        chk("rel_b_count", dec_count, 32'd9);

        // Accept and pop together at occupancy 1
        drive(32'h500, 2'b11, ADDI5, ADDI5);
        tick();
        chk("ovl_d_pc", out_pc, 32'h500);
        drive(32'h600, 2'b11, ADDI5, ADDI5);
        tick();
        in_valid = 1'b0;
        chk("ovl_e_valid", out_valid, 1'b1);
        chk("ovl_e_pc", out_pc, 32'h600);
        chk("ovl_e_ready", in_ready, 1'b1);
        chk("ovl_d_count", dec_count, 32'd11);
        tick();
        chk("ovl_drained", out_valid, 1'b0);
        chk("ovl_count", dec_count, 32'd13);

        // Flush at occupancy 2 with a bundle offered
        out_ready = 1'b0;
        drive(32'h700, 2'b11, ADD3, ADD3);
        tick();
        drive(32'h800, 2'b11, ADD3, ADD3);
        tick();
        chk("fl_full_ready", in_ready, 1'b0);
        flush = 1'b1;
        drive(32'h900, 2'b11, ADD3, ADD3);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("fl_never_seen", out_valid, 1'b0);
        chk("fl_count", dec_count, 32'd13);

        // Pop in a flush cycle still counts
        out_ready = 1'b0;
        drive(32'hA00, 2'b11, ADD3, ADD3);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flpop_valid", out_valid, 1'b0);
        chk("flpop_count", dec_count, 32'd15);

        // Saturation of the 4-bit counter
        rst_n = 1'b0;
        #2;
        chk("rst2_count", dec_count, 32'd0);
        chk("rst2_m_count", m_dec_count, 4'd0);
        rst_n = 1'b1;
        tick();
        chk("rst2_ready", in_ready, 1'b1);
        for (int n = 0; n < 7; n++) begin
            drive(32'h1000, 2'b11, ADDI5, ADDI5);
            tick();
        end
        drive(32'h1000, 2'b01, ADDI5, ADDI5);
        tick();
        in_valid = 1'b0;
        tick();
        chk("sat_pre_m", m_dec_count, 4'hF);
        chk("sat_pre", dec_count, 32'd15);
        drive(32'h1100, 2'b11, ADDI5, ADDI5);
        tick();
        in_valid = 1'b0;
        tick();
        chk("sat_m", m_dec_count, 4'hF);
        chk("sat_wide", dec_count, 32'd17);

        // Asynchronous reset while a bundle is stalled
        out_ready = 1'b0;
        drive(32'h1200, 2'b11, ADD3, ADD3);
        tick();
        in_valid = 1'b0;
        chk("arst_pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_lane_valid", out_lane_valid, 2'b00);
        chk("arst_illegal", out_illegal, 2'b00);
        chk("arst_count", dec_count, 32'd0);
        chk("arst_m_count", m_dec_count, 4'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("arst_ready", in_ready, 1'b1);
        chk("arst_dropped", out_valid, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("arst_count_after", dec_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
